// File: rtl/fu_arbiter.sv
// fu_arbiter: shares one combinational function unit between two requesters.
// An accepted operation is latched, presented to the function unit for one
// cycle (EXEC), and its result is captured and held as a response (RESP)
// until the consumer takes it.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid / reqN_ready    requester N handshake (N = 0, 1)
//   reqN_a, reqN_b, reqN_fs    requester N operands and function select
//   fu_a, fu_b, fu_fs          registered operands to the function unit
//   fu_s, fu_flags             function unit result and ZCNV flags
//   rsp_valid / rsp_ready      response handshake
//   rsp_id, rsp_s, rsp_flags   owner, result and flags of the response
//   rsp_err                    accepted fs was not a legal code
//   op_count                   completed response handshakes (wraps)
//
// Parameter
//   RR_EN  1 = round-robin between requesters, 0 = requester 0 always wins
module fu_arbiter #(
  parameter int unsigned RR_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_fs,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_fs,
  output logic [31:0] fu_a,
  output logic [31:0] fu_b,
  output logic [3:0]  fu_fs,
  input  logic [31:0] fu_s,
  input  logic [3:0]  fu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_s,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  fs_q, fs_d;
  logic        id_q, id_d;
  logic        err_q, err_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_s_q, rsp_s_d;
  logic [3:0]  rsp_flags_q, rsp_flags_d;
  logic        rsp_err_q, rsp_err_d;
  logic [15:0] op_count_q, op_count_d;

  logic        grant_id_s;
  logic        accept_s;
  logic [31:0] sel_a_s;
  logic [31:0] sel_b_s;
  logic [3:0]  sel_fs_s;

  // Set of function-select codes the function unit implements.
  function automatic logic fs_is_legal(input logic [3:0] fs);
    case (fs)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0110,
      4'b1000, 4'b1010, 4'b1011, 4'b1100, 4'b1110: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

  // Arbitration: pick a winner and decide whether an accept happens this cycle.
  always_comb begin
    grant_id_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id_s = (RR_EN != 0) ? prio_q : 1'b0;
    end else if (req1_valid) begin
      grant_id_s = 1'b1;
    end else begin
      grant_id_s = 1'b0;
    end
    // rst_n gates the accept so both readys read 0 for the whole reset.
    accept_s = (state_q == IDLE) && (req0_valid || req1_valid) && rst_n;
    sel_a_s  = grant_id_s ? req1_a  : req0_a;
    sel_b_s  = grant_id_s ? req1_b  : req0_b;
    sel_fs_s = grant_id_s ? req1_fs : req0_fs;
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    a_d         = a_q;
    b_d         = b_q;
    fs_d        = fs_q;
    id_d        = id_q;
    err_d       = err_q;
    rsp_id_d    = rsp_id_q;
    rsp_s_d     = rsp_s_q;
    rsp_flags_d = rsp_flags_q;
    rsp_err_d   = rsp_err_q;
    op_count_d  = op_count_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = EXEC;
          a_d     = sel_a_s;
          b_d     = sel_b_s;
          id_d    = grant_id_s;
          // An illegal code is replaced by 0000 so the unit never sees it.
          if (fs_is_legal(sel_fs_s)) begin
            fs_d  = sel_fs_s;
            err_d = 1'b0;
          end else begin
            fs_d  = 4'b0000;
            err_d = 1'b1;
          end
          if (RR_EN != 0) begin
            prio_d = ~grant_id_s;
          end else begin
            prio_d = prio_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        state_d   = RESP;
        rsp_id_d  = id_q;
        rsp_err_d = err_q;
        if (err_q) begin
          rsp_s_d     = 32'd0;
          rsp_flags_d = 4'd0;
        end else begin
          rsp_s_d     = fu_s;
          rsp_flags_d = fu_flags;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d    = IDLE;
          op_count_d = op_count_q + 16'd1;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      fs_q        <= 4'd0;
      id_q        <= 1'b0;
      err_q       <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_s_q     <= 32'd0;
      rsp_flags_q <= 4'd0;
      rsp_err_q   <= 1'b0;
      op_count_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      a_q         <= a_d;
      b_q         <= b_d;
      fs_q        <= fs_d;
      id_q        <= id_d;
      err_q       <= err_d;
      rsp_id_q    <= rsp_id_d;
      rsp_s_q     <= rsp_s_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_err_q   <= rsp_err_d;
      op_count_q  <= op_count_d;
    end
  end

  assign req0_ready = accept_s && !grant_id_s;
  assign req1_ready = accept_s && grant_id_s;
  assign fu_a       = a_q;
  assign fu_b       = b_q;
  assign fu_fs      = fs_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_s      = rsp_s_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_fu_arbiter.sv
// Directed bench for fu_arbiter. u_rr (RR_EN=1) and u_fp (RR_EN=0) share all
// stimulus; each drives its own copy of a small function-unit model
// (0000 add, 0001 sub, others xor; flags = {Z, N, 2'b00}).
module tb_fu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, rsp_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_fs, req1_fs;

  logic        r_req0_ready, r_req1_ready, r_rsp_valid, r_rsp_id, r_rsp_err;
  logic [31:0] r_fu_a, r_fu_b, r_fu_s, r_rsp_s;
  logic [3:0]  r_fu_fs, r_fu_flags, r_rsp_flags;
  logic [15:0] r_op_count;

  logic        f_req0_ready, f_req1_ready, f_rsp_valid, f_rsp_id, f_rsp_err;
  logic [31:0] f_fu_a, f_fu_b, f_fu_s, f_rsp_s;
  logic [3:0]  f_fu_fs, f_fu_flags, f_rsp_flags;
  logic [15:0] f_op_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [35:0] fu_model(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] fs);
    logic [31:0] s;
    case (fs)
      4'b0000: s = a + b;
      4'b0001: s = a - b;
      default: s = a ^ b;
    endcase
    return {s, (s == 32'd0), s[31], 2'b00};
  endfunction

  assign {r_fu_s, r_fu_flags} = fu_model(r_fu_a, r_fu_b, r_fu_fs);
  assign {f_fu_s, f_fu_flags} = fu_model(f_fu_a, f_fu_b, f_fu_fs);

  fu_arbiter #(.RR_EN(1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(r_req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_fs(req0_fs),
    .req1_valid(req1_valid), .req1_ready(r_req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_fs(req1_fs),
    .fu_a(r_fu_a), .fu_b(r_fu_b), .fu_fs(r_fu_fs),
    .fu_s(r_fu_s), .fu_flags(r_fu_flags),
    .rsp_valid(r_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(r_rsp_id),
    .rsp_s(r_rsp_s), .rsp_flags(r_rsp_flags), .rsp_err(r_rsp_err),
    .op_count(r_op_count)
  );

  fu_arbiter #(.RR_EN(0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_fs(req0_fs),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_fs(req1_fs),
    .fu_a(f_fu_a), .fu_b(f_fu_b), .fu_fs(f_fu_fs),
    .fu_s(f_fu_s), .fu_flags(f_fu_flags),
    .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(f_rsp_id),
    .rsp_s(f_rsp_s), .rsp_flags(f_rsp_flags), .rsp_err(f_rsp_err),
    .op_count(f_op_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd0; req0_b = 32'd0; req0_fs = 4'd0;
    req1_valid = 1'b1; req1_a = 32'd0; req1_b = 32'd0; req1_fs = 4'd0;

    // Reset state, with both requesters asking
    @(negedge clk); @(negedge clk);
    chk("rst_req0_ready", {31'd0, r_req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'd0, r_req1_ready}, 32'd0);
    chk("rst_rsp_valid",  {31'd0, r_rsp_valid},  32'd0);
    chk("rst_op_count",   {16'd0, r_op_count},   32'd0);
    chk("rst_fu_a",       r_fu_a,                32'd0);
    chk("rst_rsp_s",      r_rsp_s,               32'd0);

    // req0 ADD 5 + 7
    req1_valid = 1'b0;
    req0_a = 32'd5; req0_b = 32'd7; req0_fs = 4'b0000;
    rst_n = 1'b1;
    #1;
    chk("add_req0_ready", {31'd0, r_req0_ready}, 32'd1);
    chk("add_req1_ready", {31'd0, r_req1_ready}, 32'd0);
    step(); req0_valid = 1'b0;
    chk("add_exec_valid", {31'd0, r_rsp_valid},  32'd0);
    chk("add_exec_ready", {31'd0, r_req0_ready}, 32'd0);
    chk("add_fu_a",       r_fu_a,                32'd5);
    step();
    chk("add_rsp_valid",  {31'd0, r_rsp_valid},  32'd1);
    chk("add_rsp_s",      r_rsp_s,               32'd12);
    chk("add_rsp_id",     {31'd0, r_rsp_id},     32'd0);
    chk("add_rsp_err",    {31'd0, r_rsp_err},    32'd0);
    step();
    chk("add_op_count",   {16'd0, r_op_count},   32'd1);
    chk("add_rsp_done",   {31'd0, r_rsp_valid},  32'd0);

    // Round-robin vs fixed priority with both valid continuously, from reset
    rst_n = 1'b0; step(); rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd1;  req0_b = 32'd1;  req0_fs = 4'b0000;
    req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd20; req1_fs = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_req0_ready", {31'd0, r_req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_req1_ready", {31'd0, r_req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("fp_req0_ready", {31'd0, f_req0_ready}, 32'd1);
      chk("fp_req1_ready", {31'd0, f_req1_ready}, 32'd0);
      step(); step();
      chk("rr_rsp_id", {31'd0, r_rsp_id}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("rr_rsp_s",  r_rsp_s,           (k % 2 == 1) ? 32'd30 : 32'd2);
      chk("fp_rsp_id", {31'd0, f_rsp_id}, 32'd0);
      step();
    end
    chk("rr_op_count", {16'd0, r_op_count}, 32'd4);

    // req1 with illegal fs 0011
    req0_valid = 1'b0;
    req1_a = 32'd3; req1_b = 32'd4; req1_fs = 4'b0011;
    #1;
    chk("ill_req1_ready", {31'd0, r_req1_ready}, 32'd1);
    step(); req1_valid = 1'b0;
    chk("ill_fu_fs",      {28'd0, r_fu_fs},      32'd0);
    chk("ill_fu_a",       r_fu_a,                32'd3);
    step();
    chk("ill_rsp_err",    {31'd0, r_rsp_err},    32'd1);
    chk("ill_rsp_s",      r_rsp_s,               32'd0);
    chk("ill_rsp_flags",  {28'd0, r_rsp_flags},  32'd0);
    chk("ill_rsp_id",     {31'd0, r_rsp_id},     32'd1);
    step();
    chk("ill_op_count",   {16'd0, r_op_count},   32'd5);

    // Backpressure: rsp_ready low for 5 cycles while req1 waits
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd50; req0_fs = 4'b0001;
    step(); req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd5; req1_fs = 4'b0001;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid",  {31'd0, r_rsp_valid},  32'd1);
      chk("bp_rsp_s",      r_rsp_s,               32'd50);
      chk("bp_rsp_id",     {31'd0, r_rsp_id},     32'd0);
      chk("bp_req0_ready", {31'd0, r_req0_ready}, 32'd0);
      chk("bp_req1_ready", {31'd0, r_req1_ready}, 32'd0);
      step();
    end
    chk("bp_still_held", r_rsp_s, 32'd50);
    rsp_ready = 1'b1;
    step();
    #1;
    chk("bp_next_accept", {31'd0, r_req1_ready}, 32'd1);
    chk("bp_op_count",    {16'd0, r_op_count},   32'd6);
    step(); req1_valid = 1'b0;
    step();
    chk("bp2_rsp_id",     {31'd0, r_rsp_id},     32'd1);
    chk("bp2_rsp_s",      r_rsp_s,               32'd0);
    chk("bp2_rsp_flags",  {28'd0, r_rsp_flags},  32'd8);
    step();
    chk("bp2_op_count",   {16'd0, r_op_count},   32'd7);

    // Reset during EXEC of SUB 1 - 2 (prio is 1 after this accept)
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_fs = 4'b0001;
    step(); req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rsp_valid",  {31'd0, r_rsp_valid},  32'd0);
    chk("mid_op_count",   {16'd0, r_op_count},   32'd0);
    chk("mid_fu_a",       r_fu_a,                32'd0);
    step();
    chk("mid_rsp_valid2", {31'd0, r_rsp_valid},  32'd0);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd9;  req0_b = 32'd1; req0_fs = 4'b0000;
    req1_valid = 1'b1; req1_a = 32'd40; req1_b = 32'd2; req1_fs = 4'b0000;
    #1;
    chk("post_req0_ready", {31'd0, r_req0_ready}, 32'd1);
    chk("post_req1_ready", {31'd0, r_req1_ready}, 32'd0);
    step(); req0_valid = 1'b0; req1_valid = 1'b0;
    chk("post_exec_valid", {31'd0, r_rsp_valid},  32'd0);
    step();
    chk("post_rsp_s",      r_rsp_s,               32'd10);
    chk("post_rsp_id",     {31'd0, r_rsp_id},     32'd0);
    step();
    chk("post_op_count",   {16'd0, r_op_count},   32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
